// File: rtl/cordic_cosine.sv
// rtl/cordic_cosine.sv - iterative rotation-mode CORDIC cosine, one micro-rotation per clock
//
// Purpose:
//   Computes cos(angle) for a signed binary angle (angle_rad = angle*pi/2^WIDTH)
//   by a rotation-mode CORDIC running one micro-rotation per clock. A
//   start/ready/done handshake wraps the iteration. The result is a signed
//   fixed-point value with 1.0 = 2^(WIDTH-2), Q2.30 at WIDTH=32.
//
// Parameters:
//   WIDTH       angle/value width in bits (table is built for WIDTH <= 32)
//   ITERATIONS  micro-rotations per result (1..WIDTH-2)
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-low reset
//   start      in   1      request, sampled only while ready=1
//   angle      in   WIDTH  signed binary angle, latched on the accepting edge
//   ready      out  1      high in IDLE
//   done       out  1      high in DONE, value valid and stable
//   value      out  WIDTH  signed cosine, saturated to WIDTH bits
//   value_sin  out  WIDTH  signed sine, saturated (only with CORDIC_SINE_OUT_EN)
//
// Optional feature macro: CORDIC_SINE_OUT_EN adds the value_sin output port.

`timescale 1ns/1ps

module cordic_cosine #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] angle,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] value
`ifdef CORDIC_SINE_OUT_EN
    ,
    output logic [WIDTH-1:0] value_sin
`endif
);

    // x/y carry two guard bits so the CORDIC gain never wraps; z carries one
    // so a residual angle just past +-pi/2 during convergence cannot wrap.
    localparam int XW          = WIDTH + 2;
    localparam int ZW          = WIDTH + 1;
    localparam int IW          = $clog2(ITERATIONS + 1);
    localparam int SCALE_SHIFT = 32 - WIDTH;

    // Constants below are stored at 32-bit scale and rounded down to WIDTH.
    localparam logic [63:0] HALF_LSB = (64'd1 << SCALE_SHIFT) >> 1;
    localparam logic [63:0] K64      = (64'd652032874 + HALF_LSB) >> SCALE_SHIFT;
    localparam logic [XW-1:0] K_INIT = K64[XW-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t                r_state;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic signed [ZW-1:0]  r_z;
    logic [IW-1:0]         r_iter;

    // atan(2^-i) scaled so that pi maps to 2^32, rounded.
    function automatic logic [ZW-1:0] atan_lut(input logic [IW-1:0] idx);
        logic [63:0] t;
        t = 64'd0;
        case (5'(idx))
            5'd0:  t = 64'd1073741824;
            5'd1:  t = 64'd633866811;
            5'd2:  t = 64'd334917815;
            5'd3:  t = 64'd170009512;
            5'd4:  t = 64'd85334662;
            5'd5:  t = 64'd42708931;
            5'd6:  t = 64'd21359677;
            5'd7:  t = 64'd10680490;
            5'd8:  t = 64'd5340327;
            5'd9:  t = 64'd2670173;
            5'd10: t = 64'd1335088;
            5'd11: t = 64'd667544;
            5'd12: t = 64'd333772;
            5'd13: t = 64'd166886;
            5'd14: t = 64'd83443;
            5'd15: t = 64'd41722;
            5'd16: t = 64'd20861;
            5'd17: t = 64'd10430;
            5'd18: t = 64'd5215;
            5'd19: t = 64'd2608;
            5'd20: t = 64'd1304;
            5'd21: t = 64'd652;
            5'd22: t = 64'd326;
            5'd23: t = 64'd163;
            5'd24: t = 64'd81;
            5'd25: t = 64'd41;
            5'd26: t = 64'd20;
            5'd27: t = 64'd10;
            5'd28: t = 64'd5;
            5'd29: t = 64'd3;
            5'd30: t = 64'd1;
            5'd31: t = 64'd1;
        endcase
        t = (t + HALF_LSB) >> SCALE_SHIFT;
        return t[ZW-1:0];
    endfunction

    // Clamp an internal x/y value into the WIDTH-bit signed output range.
    function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        logic [XW-WIDTH:0] top;
        top = v[XW-1:WIDTH-1];
        if ((&top) || !(|top)) begin
            return v[WIDTH-1:0];
        end else if (v[XW-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    logic                  w_dir_pos;
    logic signed [XW-1:0]  w_x_shr;
    logic signed [XW-1:0]  w_y_shr;
    logic signed [ZW-1:0]  w_atan;
    logic signed [XW-1:0]  w_x_next;
    logic signed [XW-1:0]  w_y_next;
    logic signed [ZW-1:0]  w_z_next;
    logic [WIDTH-1:0]      w_x_sat;

    // Rotate toward z=0: positive residual angle rotates counter-clockwise.
    assign w_dir_pos = ~r_z[ZW-1];
    assign w_x_shr   = r_x >>> r_iter;
    assign w_y_shr   = r_y >>> r_iter;
    assign w_atan    = atan_lut(r_iter);
    assign w_x_next  = w_dir_pos ? (r_x - w_y_shr) : (r_x + w_y_shr);
    assign w_y_next  = w_dir_pos ? (r_y + w_x_shr) : (r_y - w_x_shr);
    assign w_z_next  = w_dir_pos ? (r_z - w_atan)  : (r_z + w_atan);
    assign w_x_sat   = sat(r_x);

`ifdef CORDIC_SINE_OUT_EN
    logic [WIDTH-1:0] w_y_sat;
    assign w_y_sat = sat(r_y);
`else
    // Sine stays internal: y is still rotated because x depends on it.
`endif

    // The ITER state spends ITERATIONS cycles rotating and one more cycle
    // publishing the final x, so done rises ITERATIONS+1 edges after start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            value   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
`ifdef CORDIC_SINE_OUT_EN
            value_sin <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= K_INIT;
                        r_y     <= '0;
                        r_z     <= {angle[WIDTH-1], angle};
                        r_iter  <= '0;
                        ready   <= 1'b0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (r_iter == IW'(ITERATIONS)) begin
                        value   <= w_x_sat;
`ifdef CORDIC_SINE_OUT_EN
                        value_sin <= w_y_sat;
`endif
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_x    <= w_x_next;
                        r_y    <= w_y_next;
                        r_z    <= w_z_next;
                        r_iter <= r_iter + IW'(1);
                    end
                end
                S_DONE: begin
                    // A start held high from the previous request must drop
                    // before another one can be accepted.
                    if (!start) begin
                        done    <= 1'b0;
                        ready   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_cosine.sv
// tb/tb_cordic_cosine.sv - self-checking bench for cordic_cosine

`timescale 1ns/1ps

module tb_cordic_cosine;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 30;
    localparam longint TOL    = 256;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] angle;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] value;
`ifdef CORDIC_SINE_OUT_EN
    logic [WIDTH-1:0] value_sin;
`endif

    always #5 clk = ~clk;

    cordic_cosine #(
        .WIDTH      (WIDTH),
        .ITERATIONS (ITERATIONS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .angle     (angle),
        .ready     (ready),
        .done      (done),
        .value     (value)
`ifdef CORDIC_SINE_OUT_EN
        ,
        .value_sin (value_sin)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] ang;
        longint           exp_cos;
        longint           exp_sin;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic real to_rad(input logic [WIDTH-1:0] a);
        return real'($signed(a)) * 3.14159265358979323846 / (2.0 ** WIDTH);
    endfunction

    function automatic longint model_cos(input logic [WIDTH-1:0] a);
        return longint'($cos(to_rad(a)) * (2.0 ** (WIDTH - 2)));
    endfunction

    function automatic longint model_sin(input logic [WIDTH-1:0] a);
        return longint'($sin(to_rad(a)) * (2.0 ** (WIDTH - 2)));
    endfunction

    function automatic longint abs_diff(input logic [WIDTH-1:0] v, input longint e);
        longint d;
        d = longint'($signed(v)) - e;
        return (d < 0) ? -d : d;
    endfunction

    // Waits for ready, drives one request, returns at the negedge after the
    // accepting edge. hold keeps start asserted afterwards.
    task automatic launch(input logic [WIDTH-1:0] a, input bit hold);
        sb_t e;
        int  guard;
        e.ang     = a;
        e.exp_cos = model_cos(a);
        e.exp_sin = model_sin(a);
        sb_q.push_back(e);
        @(negedge clk);
        guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL launch_ready: ready=%b required 1", ready);
        end
        angle = a;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Counts rising edges after the accepting edge until done is seen.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat);
        sb_t    e;
        longint d;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s_scoreboard: queue empty, required one entry", tag);
            return;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (lat !== ITERATIONS + 1) begin
            n_errors++;
            $display("FAIL %s_latency: angle=%h latency=%0d required %0d", tag, e.ang, lat, ITERATIONS + 1);
        end
        d = abs_diff(value, e.exp_cos);
        n_checks++;
        if (d > TOL) begin
            n_errors++;
            $display("FAIL %s_cos: angle=%h value=%0d required %0d +-%0d", tag, e.ang, $signed(value), e.exp_cos, TOL);
        end
`ifdef CORDIC_SINE_OUT_EN
        d = abs_diff(value_sin, e.exp_sin);
        n_checks++;
        if (d > TOL) begin
            n_errors++;
            $display("FAIL %s_sin: angle=%h value_sin=%0d required %0d +-%0d", tag, e.ang, $signed(value_sin), e.exp_sin, TOL);
        end
`endif
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        angle = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: ready=%b required 1", ready); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: done=%b required 0", done); end
        n_checks++;
        if (value !== '0) begin n_errors++; $display("FAIL reset_value: value=%h required 0", value); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: ready=%b done=%b required 1 0", ready, done);
        end
    endtask

    task automatic test_angles;
        logic [WIDTH-1:0] tbl [11];
        int lat;
        tbl = '{32'h00000000, 32'h40000000, 32'hC0000000, 32'd1431655770,
                32'd2863311540, 32'h7FFFFFFF, 32'h80000000, 32'h20000000,
                32'hE0000000, 32'h60000000, 32'hA0000000};
        foreach (tbl[i]) begin
            launch(tbl[i], 1'b0);
            wait_done(0, lat);
            check_result("angle", lat);
            @(posedge clk);
            #1;
            n_checks++;
            if (ready !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL angle_idle: angle=%h ready=%b done=%b required 1 0", tbl[i], ready, done);
            end
            repeat (2) @(posedge clk);
            #1;
            n_checks++;
            if (abs_diff(value, model_cos(tbl[i])) > TOL) begin
                n_errors++;
                $display("FAIL angle_hold: angle=%h value=%0d required %0d", tbl[i], $signed(value), model_cos(tbl[i]));
            end
        end
    endtask

    task automatic test_handshake;
        int lat;
        launch(32'd1431655770, 1'b0);
        @(negedge clk);
        start = 1'b1;
        angle = 32'h00000000;
        @(negedge clk);
        start = 1'b0;
        angle = 32'h40000000;
        n_checks++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_flags: ready=%b done=%b required 0 0", ready, done);
        end
        wait_done(2, lat);
        check_result("busy", lat);
    endtask

    task automatic test_hold_start;
        int lat;
        int rises;
        launch(32'h00000000, 1'b1);
        wait_done(0, lat);
        check_result("hold", lat);
        repeat (5) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b1 || ready !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_done: done=%b ready=%b required 1 0", done, ready);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_release: done=%b ready=%b required 0 1", done, ready);
        end
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) rises++;
        end
        n_checks++;
        if (rises !== 0) begin
            n_errors++;
            $display("FAIL hold_single: extra done cycles=%0d required 0", rises);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] a;
        int lat;
        for (int k = 0; k < 8; k++) begin
            a = $urandom();
            launch(a, 1'b0);
            wait_done(0, lat);
            check_result("b2b", lat);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int rises;
        launch(32'h40000000, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || value !== '0 || ready !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_async: done=%b value=%h ready=%b required 0 0 1", done, value, ready);
        end
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) rises++;
        end
        n_checks++;
        if (rises !== 0) begin
            n_errors++;
            $display("FAIL abort_noresult: done cycles=%0d required 0", rises);
        end
        launch(32'd2863311540, 1'b0);
        wait_done(0, lat);
        check_result("recover", lat);
    endtask

    initial begin
        test_reset();
        test_angles();
        test_handshake();
        test_hold_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
